multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multicycle RV32I-style datapath.
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction,
// drives the datapath enables for each step and counts retired
// instructions (one per PC update). Unsupported opcodes park the block
// in TRAP until reset.
//
// State table (state | meaning):
//   FETCH  (0) | request instruction fetch, load IR on mem_ready
//   DECODE (1) | latch opcode, check it is supported
//   EXEC   (2) | ALU step; branches resolve and update PC here
//   MEM    (3) | data load/store, held until mem_ready
//   WB     (4) | register writeback and PC update
//   TRAP   (7) | unsupported opcode, left only through reset
//   5, 6       | unused, return to FETCH
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   instr_word[31:0] instruction register contents (opcode used in DECODE)
//   mem_ready        memory access complete (FETCH and MEM only)
//   branch_taken     branch compare result (EXEC only)
//   state_out[2:0]   current state encoding
//   mem_req, mem_we  memory request / write strobe
//   ir_we, pc_we     instruction register / PC write enables
//   pc_src[1:0]      0 = PC+4, 1 = PC+imm, 2 = ALU result
//   reg_we           register file write enable
//   wb_sel[1:0]      0 = ALU, 1 = memory data, 2 = PC+4
//   alu_src_b        0 = rs2, 1 = immediate
//   illegal          trap indicator
//   instret[31:0]    retired-instruction count
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_word,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t      r_state;
    logic [6:0]  r_opcode;
    logic [31:0] r_instret;

    state_t      w_next_state;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_ir_we;
    logic        w_pc_we;
    logic [1:0]  w_pc_src;
    logic        w_reg_we;
    logic [1:0]  w_wb_sel;
    logic        w_alu_src_b;
    logic        w_illegal;
    logic        w_legal;
    logic        w_alu_imm;
    logic        w_is_store;

    // Only the opcode field matters to control.
    logic w_unused;
    assign w_unused = ^instr_word[31:7];

    always_comb begin
        w_legal = 1'b0;
        case (instr_word[6:0])
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_legal = 1'b1;
            default:                           w_legal = 1'b0;
        endcase
    end

    // Register-register ALU ops and branch compares take rs2; all else imm.
    assign w_alu_imm  = (r_opcode != OP_R) && (r_opcode != OP_BRANCH);
    assign w_is_store = (r_opcode == OP_STORE);

    always_comb begin
        w_next_state = S_FETCH;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = 2'd0;
        w_reg_we     = 1'b0;
        w_wb_sel     = 2'd0;
        w_alu_src_b  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                w_next_state = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                w_alu_src_b = w_alu_imm;
                case (r_opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEM;
                    OP_BRANCH: begin
                        w_pc_we      = 1'b1;
                        w_pc_src     = {1'b0, branch_taken};
                        w_next_state = S_FETCH;
                    end
                    default: w_next_state = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_we    = w_is_store;
                w_alu_src_b = w_alu_imm;
                if (mem_ready) begin
                    if (w_is_store) begin
                        w_pc_we      = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                case (r_opcode)
                    OP_LOAD: w_wb_sel = 2'd1;
                    OP_JAL: begin
                        w_wb_sel = 2'd2;
                        w_pc_src = 2'd1;
                    end
                    OP_JALR: begin
                        w_wb_sel = 2'd2;
                        w_pc_src = 2'd2;
                    end
                    default: w_wb_sel = 2'd0;
                endcase
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = S_TRAP;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_opcode  <= 7'd0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_opcode <= instr_word[6:0];
            end
            if (w_pc_we) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Reset blanks every output immediately, so an access in flight is
    // dropped in the same cycle reset is seen.
    assign state_out = rst ? 3'd0  : r_state;
    assign mem_req   = w_mem_req   & ~rst;
    assign mem_we    = w_mem_we    & ~rst;
    assign ir_we     = w_ir_we     & ~rst;
    assign pc_we     = w_pc_we     & ~rst;
    assign pc_src    = rst ? 2'd0  : w_pc_src;
    assign reg_we    = w_reg_we    & ~rst;
    assign wb_sel    = rst ? 2'd0  : w_wb_sel;
    assign alu_src_b = w_alu_src_b & ~rst;
    assign illegal   = w_illegal   & ~rst;
    assign instret   = rst ? 32'd0 : r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_word = 32'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [2:0]  state_out;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b, illegal;
    logic [1:0]  pc_src, wb_sel;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_word   (instr_word),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .state_out    (state_out),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .alu_src_b    (alu_src_b),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] instret_m = 32'd0;

    // Expected behaviour of one clock cycle plus the inputs applied in it.
    typedef struct {
        logic [2:0]  st;
        logic        rdy;
        logic        bt;
        logic [31:0] iw;
        logic        mreq, mwe, irwe, pcwe, regwe, alub, ill;
        logic [1:0]  pcsrc, wbsel;
    } cyc_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    endfunction

    // Idle cycle of a given state: no control asserted, ignored inputs random.
    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c.st = st;   c.rdy = 1'($urandom); c.bt = 1'($urandom); c.iw = $urandom;
        c.mreq = 0;  c.mwe = 0; c.irwe = 0; c.pcwe = 0; c.regwe = 0;
        c.alub = 0;  c.ill = 0; c.pcsrc = 2'd0; c.wbsel = 2'd0;
        return c;
    endfunction

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem_ready = 1'($urandom); branch_taken = 1'($urandom); instr_word = $urandom;
            #1;
            check("rst_state", 32'(state_out), 0);
            check("rst_mem_req", 32'(mem_req), 0);
            check("rst_mem_we", 32'(mem_we), 0);
            check("rst_ir_we", 32'(ir_we), 0);
            check("rst_pc_we", 32'(pc_we), 0);
            check("rst_reg_we", 32'(reg_we), 0);
            check("rst_pc_src", 32'(pc_src), 0);
            check("rst_wb_sel", 32'(wb_sel), 0);
            check("rst_alu_src_b", 32'(alu_src_b), 0);
            check("rst_illegal", 32'(illegal), 0);
            check("rst_instret", instret, 0);
        end
        instret_m = 32'd0;
    endtask

    // One instruction: nf fetch stalls, nm memory stalls, ntrap trap cycles
    // observed before reset; abort_at >= 0 replaces that cycle with reset.
    task automatic run_instr(input logic [31:0] instr, input int nf, input int nm,
                             input bit bt, input int ntrap, input int abort_at);
        cyc_t q[$];
        cyc_t c;
        logic [6:0] op;
        bit need_rst;
        op = instr[6:0];
        need_rst = 0;
        for (int i = 0; i < nf; i++) begin
            c = mk(3'd0); c.rdy = 0; c.mreq = 1; q.push_back(c);
        end
        c = mk(3'd0); c.rdy = 1; c.mreq = 1; c.irwe = 1; q.push_back(c);
        c = mk(3'd1); c.iw = instr; q.push_back(c);
        if (!is_legal(op)) begin
            for (int i = 0; i < ntrap; i++) begin
                c = mk(3'd7); c.ill = 1; q.push_back(c);
            end
            need_rst = 1;
        end else begin
            c = mk(3'd2);
            c.alub = (op != 7'b0110011) && (op != 7'b1100011);
            if (op == 7'b1100011) begin
                c.bt = bt; c.pcwe = 1; c.pcsrc = bt ? 2'd1 : 2'd0;
            end
            q.push_back(c);
            if (op == 7'b0000011 || op == 7'b0100011) begin
                for (int i = 0; i <= nm; i++) begin
                    c = mk(3'd3);
                    c.rdy = (i == nm); c.mreq = 1; c.mwe = (op == 7'b0100011); c.alub = 1;
                    c.pcwe = (i == nm) && (op == 7'b0100011);
                    q.push_back(c);
                end
            end
            if (op != 7'b1100011 && op != 7'b0100011) begin
                c = mk(3'd4); c.regwe = 1; c.pcwe = 1;
                c.wbsel = (op == 7'b0000011) ? 2'd1 :
                          (op == 7'b1101111 || op == 7'b1100111) ? 2'd2 : 2'd0;
                c.pcsrc = (op == 7'b1101111) ? 2'd1 : (op == 7'b1100111) ? 2'd2 : 2'd0;
                q.push_back(c);
            end
        end
        for (int k = 0; k < q.size(); k++) begin
            if (k == abort_at) begin
                need_rst = 1;
                break;
            end
            c = q[k];
            @(negedge clk);
            rst = 1'b0;
            mem_ready = c.rdy; branch_taken = c.bt; instr_word = c.iw;
            #1;
            check("state_out", 32'(state_out), 32'(c.st));
            check("mem_req", 32'(mem_req), 32'(c.mreq));
            check("mem_we", 32'(mem_we), 32'(c.mwe));
            check("ir_we", 32'(ir_we), 32'(c.irwe));
            check("pc_we", 32'(pc_we), 32'(c.pcwe));
            check("pc_src", 32'(pc_src), 32'(c.pcsrc));
            check("reg_we", 32'(reg_we), 32'(c.regwe));
            check("wb_sel", 32'(wb_sel), 32'(c.wbsel));
            check("alu_src_b", 32'(alu_src_b), 32'(c.alub));
            check("illegal", 32'(illegal), 32'(c.ill));
            check("instret", instret, instret_m);
            if (c.pcwe) instret_m = instret_m + 32'd1;
        end
        if (need_rst) do_reset(1 + int'($urandom_range(0, 1)));
    endtask

    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
        7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    initial begin
        logic [31:0] iw;
        logic [6:0]  op;
        int          ab;
        do_reset(2);
        run_instr(32'h002081B3, 0, 0, 0, 0, -1);   // ADD
        run_instr(32'h0000A103, 0, 2, 0, 0, -1);   // LW, two MEM stalls
        run_instr(32'h00208463, 0, 0, 1, 0, -1);   // BEQ taken
        run_instr(32'h00208463, 0, 0, 0, 0, -1);   // BEQ not taken
        run_instr(32'h000080E7, 0, 0, 0, 0, -1);   // JALR
        run_instr(32'h0020A023, 1, 3, 0, 0, 5);    // SW, reset during stalled MEM
        run_instr(32'h0000007F, 0, 0, 0, 10, -1);  // illegal, 10 trap cycles
        for (int t = 0; t < 300; t++) begin
            iw = $urandom;
            if ($urandom_range(0, 11) == 0) begin
                do op = 7'($urandom); while (is_legal(op));
            end else begin
                op = LEGAL_OPS[$urandom_range(0, 8)];
            end
            iw[6:0] = op;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(iw, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom), int'($urandom_range(1, 5)), ab);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
